miriscv_alu_arbiter: RTL and testbench

Shares one miriscv_alu instance between two requesters, e.g. the main execute path (port 0) and a branch/address helper (port 1). The block arbitrates round-robin, latches the winning operation, drives the ALU from registers for one execute cycle, and captures result and comparison flag. It then returns the result on the winner's response channel with a valid/ready handshake. The ALU is instantiated outside the block and connected via the alu_* ports.

---
 rtl/miriscv_alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_miriscv_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_alu_arbiter.sv
// -----------------------------------------------------------------------------
// miriscv_alu_arbiter
// Shares one externally instantiated miriscv_alu between two requesters.
// A request is accepted in IDLE, its operator/operands are latched and driven
// to the ALU from registers for one EXEC cycle. The ALU result and comparison
// flag are captured at the end of EXEC. They are then presented on the winning
// port's response channel until that port's consumer is ready.
//
// Ports
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o    request handshake, port N (0 or 1)
//   reqN_op_i, reqN_a_i, reqN_b_i  operator and operands, port N
//   rspN_valid_o / rspN_ready_i    response handshake, port N
//   rsp_result_o, rsp_flag_o       shared registered result / comparison flag
//   alu_op_o, alu_a_o, alu_b_o     registered drive to the ALU inputs
//   alu_result_i, alu_flag_i       ALU result_o / comparsion_result_o
// -----------------------------------------------------------------------------
module miriscv_alu_arbiter #(
   parameter int unsigned RR_ENABLE = 1,
   parameter int unsigned OP_W      = 4,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [OP_W-1:0]   req0_op_i,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [OP_W-1:0]   req1_op_i,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   output logic              rsp0_valid_o,
   input  logic              rsp0_ready_i,
   output logic              rsp1_valid_o,
   input  logic              rsp1_ready_i,
   output logic [DATA_W-1:0] rsp_result_o,
   output logic              rsp_flag_o,
   output logic [OP_W-1:0]   alu_op_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_flag_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic                last_grant_r;
   logic                owner_r;
   logic [OP_W-1:0]     op_r;
   logic [DATA_W-1:0]   a_r;
   logic [DATA_W-1:0]   b_r;
   logic [DATA_W-1:0]   result_r;
   logic                flag_r;
   logic                rsp0_valid_r;
   logic                rsp1_valid_r;

   logic                grant_s;
   logic                accept_s;
   logic                rsp_done_s;

   // Grant selection: a lone requester wins; on a tie the port that did not
   // win last time wins (round-robin), or port 0 always wins (fixed priority).
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         if (RR_ENABLE != 32'd0) begin
            grant_s = ~last_grant_r;
         end else begin
            grant_s = 1'b0;
         end
      end else if (req1_valid_i) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Handshake qualifiers: acceptance only from IDLE, completion only by the owner.
   always_comb begin
      accept_s     = (state_r == ST_IDLE) && (req0_valid_i || req1_valid_i);
      req0_ready_o = (state_r == ST_IDLE) && req0_valid_i && !grant_s;
      req1_ready_o = (state_r == ST_IDLE) && req1_valid_i && grant_s;
      if (owner_r) begin
         rsp_done_s = rsp1_valid_r && rsp1_ready_i;
      end else begin
         rsp_done_s = rsp0_valid_r && rsp0_ready_i;
      end
   end

   // Arbitration FSM with latched operation, captured result and response valids.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
         owner_r      <= 1'b0;
         op_r         <= {OP_W{1'b0}};
         a_r          <= {DATA_W{1'b0}};
         b_r          <= {DATA_W{1'b0}};
         result_r     <= {DATA_W{1'b0}};
         flag_r       <= 1'b0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r         <= grant_s ? req1_op_i : req0_op_i;
                  a_r          <= grant_s ? req1_a_i  : req0_a_i;
                  b_r          <= grant_s ? req1_b_i  : req0_b_i;
                  owner_r      <= grant_s;
                  last_grant_r <= grant_s;
                  state_r      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // ALU sees the latched operation during this cycle.
               result_r     <= alu_result_i;
               flag_r       <= alu_flag_i;
               rsp0_valid_r <= ~owner_r;
               rsp1_valid_r <= owner_r;
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_done_s) begin
                  rsp0_valid_r <= 1'b0;
                  rsp1_valid_r <= 1'b0;
                  state_r      <= ST_IDLE;
               end
            end
            default: begin
               rsp0_valid_r <= 1'b0;
               rsp1_valid_r <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp0_valid_o = rsp0_valid_r;
   assign rsp1_valid_o = rsp1_valid_r;
   assign rsp_result_o = result_r;
   assign rsp_flag_o   = flag_r;
   assign alu_op_o     = op_r;
   assign alu_a_o      = a_r;
   assign alu_b_o      = b_r;

endmodule

// File: tb/tb_miriscv_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_miriscv_alu_arbiter
// Directed bench for miriscv_alu_arbiter. Two instances share every input:
// dut_rr (RR_ENABLE=1) and dut_fp (RR_ENABLE=0). Each drives its own
// behavioural ALU model. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_miriscv_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_SLL = 4'd5;
   localparam logic [3:0] OP_SRL = 4'd6;
   localparam logic [3:0] OP_SRA = 4'd7;
   localparam logic [3:0] OP_LTS = 4'd8;
   localparam logic [3:0] OP_LTU = 4'd9;
   localparam logic [3:0] OP_GES = 4'd10;
   localparam logic [3:0] OP_GEU = 4'd11;
   localparam logic [3:0] OP_EQ  = 4'd12;
   localparam logic [3:0] OP_NE  = 4'd13;

   logic        clk;
   logic        rst_n;
   logic        v0, v1, r0rdy, r1rdy;
   logic [3:0]  op0, op1;
   logic [31:0] a0, b0, a1, b1;

   // round-robin instance outputs
   logic        q0_rdy, q1_rdy, s0_vld, s1_vld, s_flag, alu_flag;
   logic [31:0] s_res, alu_a, alu_b, alu_res;
   logic [3:0]  alu_op;
   // fixed-priority instance outputs
   logic        fq0_rdy, fq1_rdy, fs0_vld, fs1_vld, fs_flag, falu_flag;
   logic [31:0] fs_res, falu_a, falu_b, falu_res;
   logic [3:0]  falu_op;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural ALU: returns {flag, result}; compares put the flag in result[0].
   function automatic logic [32:0] alu_model(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic c;
      c = 1'b0;
      case (op)
         OP_ADD: return {1'b0, a + b};
         OP_SUB: return {1'b0, a - b};
         OP_XOR: return {1'b0, a ^ b};
         OP_OR:  return {1'b0, a | b};
         OP_AND: return {1'b0, a & b};
         OP_SLL: return {1'b0, a << b[4:0]};
         OP_SRL: return {1'b0, a >> b[4:0]};
         OP_SRA: return {1'b0, $unsigned($signed(a) >>> b[4:0])};
         OP_LTS: c = ($signed(a) < $signed(b));
         OP_LTU: c = (a < b);
         OP_GES: c = ($signed(a) >= $signed(b));
         OP_GEU: c = (a >= b);
         OP_EQ:  c = (a == b);
         OP_NE:  c = (a != b);
         default: return 33'd0;
      endcase
      return {c, 31'd0, c};
   endfunction

   assign {alu_flag, alu_res}   = alu_model(alu_op, alu_a, alu_b);
   assign {falu_flag, falu_res} = alu_model(falu_op, falu_a, falu_b);

   miriscv_alu_arbiter #(.RR_ENABLE(1), .OP_W(4), .DATA_W(32)) dut_rr (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_valid_i(v0), .req0_ready_o(q0_rdy), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
      .req1_valid_i(v1), .req1_ready_o(q1_rdy), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
      .rsp0_valid_o(s0_vld), .rsp0_ready_i(r0rdy),
      .rsp1_valid_o(s1_vld), .rsp1_ready_i(r1rdy),
      .rsp_result_o(s_res), .rsp_flag_o(s_flag),
      .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_result_i(alu_res), .alu_flag_i(alu_flag)
   );

   miriscv_alu_arbiter #(.RR_ENABLE(0), .OP_W(4), .DATA_W(32)) dut_fp (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_valid_i(v0), .req0_ready_o(fq0_rdy), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
      .req1_valid_i(v1), .req1_ready_o(fq1_rdy), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
      .rsp0_valid_o(fs0_vld), .rsp0_ready_i(r0rdy),
      .rsp1_valid_o(fs1_vld), .rsp1_ready_i(r1rdy),
      .rsp_result_o(fs_res), .rsp_flag_o(fs_flag),
      .alu_op_o(falu_op), .alu_a_o(falu_a), .alu_b_o(falu_b),
      .alu_result_i(falu_res), .alu_flag_i(falu_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; r0rdy = 1'b0; r1rdy = 1'b0;
      op0 = 4'd0; op1 = 4'd0; a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
      #1;
      // ---- reset state
      check("rst_req0_ready", q0_rdy, 32'd0);
      check("rst_req1_ready", q1_rdy, 32'd0);
      check("rst_rsp0_valid", s0_vld, 32'd0);
      check("rst_rsp1_valid", s1_vld, 32'd0);
      check("rst_result", s_res, 32'd0);
      check("rst_flag", s_flag, 32'd0);
      check("rst_alu_op", alu_op, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- 1: single ADD on port 0
      v0 = 1'b1; op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7;
      #1;
      check("s1_req0_ready", q0_rdy, 32'd1);
      check("s1_req1_ready", q1_rdy, 32'd0);
      tick();
      v0 = 1'b0;
      #1;
      check("s1_exec_alu_op", alu_op, 32'(OP_ADD));
      check("s1_exec_alu_a", alu_a, 32'd5);
      check("s1_exec_alu_b", alu_b, 32'd7);
      check("s1_exec_rsp0_valid", s0_vld, 32'd0);
      tick();
      check("s1_rsp0_valid", s0_vld, 32'd1);
      check("s1_rsp1_valid", s1_vld, 32'd0);
      check("s1_result", s_res, 32'd12);
      check("s1_flag", s_flag, 32'd0);
      r0rdy = 1'b1;
      tick();
      check("s1_done_rsp0_valid", s0_vld, 32'd0);

      // ---- 2 and 3: both ports valid every cycle (rr alternates, fp always 0)
      do_reset();
      r0rdy = 1'b1; r1rdy = 1'b1;
      v0 = 1'b1; op0 = OP_SUB; a0 = 32'd10; b0 = 32'd3;
      v1 = 1'b1; op1 = OP_LTS; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("s2_rr_req0_ready", q0_rdy, ((k % 2) == 0) ? 32'd1 : 32'd0);
         check("s2_rr_req1_ready", q1_rdy, ((k % 2) == 1) ? 32'd1 : 32'd0);
         check("s3_fp_req0_ready", fq0_rdy, 32'd1);
         check("s3_fp_req1_ready", fq1_rdy, 32'd0);
         tick();
         check("s2_exec_req_ready", {q0_rdy, q1_rdy}, 32'd0);
         tick();
         check("s2_rr_rsp0_valid", s0_vld, ((k % 2) == 0) ? 32'd1 : 32'd0);
         check("s2_rr_rsp1_valid", s1_vld, ((k % 2) == 1) ? 32'd1 : 32'd0);
         check("s2_rr_result", s_res, ((k % 2) == 0) ? 32'd7 : 32'd1);
         check("s2_rr_flag", s_flag, ((k % 2) == 0) ? 32'd0 : 32'd1);
         check("s3_fp_rsp0_valid", fs0_vld, 32'd1);
         check("s3_fp_rsp1_valid", fs1_vld, 32'd0);
         check("s3_fp_result", fs_res, 32'd7);
         tick();
      end

      // ---- 4: port 1 GEU under 5 cycles of backpressure, port 0 pending
      v0 = 1'b0; v1 = 1'b1; op1 = OP_GEU; a1 = 32'd3; b1 = 32'd3;
      r0rdy = 1'b1; r1rdy = 1'b0;
      #1;
      check("s4_req1_ready", q1_rdy, 32'd1);
      tick();
      v1 = 1'b0;
      v0 = 1'b1; op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("s4_rsp1_valid", s1_vld, 32'd1);
         check("s4_rsp0_valid", s0_vld, 32'd0);
         check("s4_result", s_res, 32'd1);
         check("s4_flag", s_flag, 32'd1);
         check("s4_req0_ready_pending", q0_rdy, 32'd0);
         if (i == 4) r1rdy = 1'b1;
         tick();
      end
      r1rdy = 1'b0;
      check("s4_rsp1_released", s1_vld, 32'd0);
      check("s4_req0_ready_after", q0_rdy, 32'd1);
      tick();
      v0 = 1'b0;
      tick();
      check("s4_port0_rsp0_valid", s0_vld, 32'd1);
      check("s4_port0_result", s_res, 32'd12);
      tick();

      // ---- 5: async reset during EXEC of SLL
      v0 = 1'b1; op0 = OP_SLL; a0 = 32'd1; b0 = 32'd4;
      #1;
      check("s5_req0_ready", q0_rdy, 32'd1);
      tick();
      v0 = 1'b0;
      check("s5_exec_alu_a", alu_a, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s5_rst_alu_op", alu_op, 32'd0);
      check("s5_rst_alu_a", alu_a, 32'd0);
      check("s5_rst_alu_b", alu_b, 32'd0);
      check("s5_rst_rsp0_valid", s0_vld, 32'd0);
      check("s5_rst_result", s_res, 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("s5_no_rsp0", s0_vld, 32'd0);
         check("s5_no_rsp1", s1_vld, 32'd0);
         tick();
      end
      v0 = 1'b1;
      #1;
      check("s5_retry_req0_ready", q0_rdy, 32'd1);
      tick();
      v0 = 1'b0;
      tick();
      check("s5_retry_rsp0_valid", s0_vld, 32'd1);
      check("s5_retry_result", s_res, 32'd16);
      tick();

      // ---- 6: back-to-back XOR then EQ on port 0, ready held high
      r0rdy = 1'b1;
      v0 = 1'b1; op0 = OP_XOR; a0 = 32'h0000_F0F0; b0 = 32'h0000_0FF0;
      #1;
      check("s6_accept0", q0_rdy, 32'd1);
      tick();
      op0 = OP_EQ; a0 = 32'd8; b0 = 32'd8;
      #1;
      check("s6_exec_req0_ready", q0_rdy, 32'd0);
      tick();
      check("s6_xor_rsp0_valid", s0_vld, 32'd1);
      check("s6_xor_result", s_res, 32'h0000_FF00);
      check("s6_xor_flag", s_flag, 32'd0);
      check("s6_resp_req0_ready", q0_rdy, 32'd0);
      tick();
      check("s6_accept1", q0_rdy, 32'd1);
      tick();
      v0 = 1'b0;
      tick();
      check("s6_eq_rsp0_valid", s0_vld, 32'd1);
      check("s6_eq_result", s_res, 32'd1);
      check("s6_eq_flag", s_flag, 32'd1);
      tick();
      check("s6_idle_rsp0_valid", s0_vld, 32'd0);
      check("s6_idle_req0_ready", q0_rdy, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
